vcfg_ctrl: RTL and testbench

//  Vector configuration unit for vsetvli / vsetivli / vsetvl, holding architectural vl and vtype.
//  - Handles full LMUL and SEW range, ELEN legality and AVL clamping against VLMAX.
//  - Sits between the decode/issue stage (request side) and scalar writeback (rd <- new vl).
//  - Valid/ready on both sides, one outstanding request; vl/vtype feed the vector lanes.

---
 rtl/vcfg_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_vcfg_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcfg_ctrl.sv
// vcfg_ctrl: vector configuration unit for vsetvli / vsetivli / vsetvl.
// Holds architectural vl and vtype, checks vtype legality against ELEN,
// clamps AVL to VLMAX and returns the new vl to scalar writeback.
// One request in flight: IDLE accepts, RESP holds the response until taken.
// Build option: define RVV_CFG_FRAC_LMUL_EN to make fractional LMUL
// (vlmul 101/110/111) legal; without it those encodings set vill.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | req_ready=1, waiting for a config instruction
// RESP  | resp_valid=1, result held until resp_ready
module vcfg_ctrl #(
    parameter int XLEN    = 32,
    parameter int VLEN    = 16384,
    parameter int ELEN    = 64,
    parameter int VL_BITS = $clog2(VLEN) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_cfg_type,
    input  logic               req_rs1_x0,
    input  logic               req_rd_x0,
    input  logic [XLEN-1:0]    req_avl,
    input  logic [XLEN-1:0]    req_vtype,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_wb_en,
    output logic [XLEN-1:0]    resp_vl,
    output logic [VL_BITS-1:0] vl,
    output logic [2:0]         vsew,
    output logic [2:0]         vlmul,
    output logic               vta,
    output logic               vma,
    output logic               vill,
    output logic               cfg_changed
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    localparam int                 CMP_W  = (XLEN > VL_BITS) ? XLEN : VL_BITS;
    localparam logic [VL_BITS-1:0] VLEN_C = VL_BITS'(VLEN);
    localparam logic [10:0]        ELEN_C = 11'(ELEN);

    logic [0:0]         state_q, state_d;
    logic [VL_BITS-1:0] vl_q, vl_d;
    logic [2:0]         vsew_q, vsew_d;
    logic [2:0]         vlmul_q, vlmul_d;
    logic               vta_q, vta_d;
    logic               vma_q, vma_d;
    logic               vill_q, vill_d;
    logic               resp_wb_en_q, resp_wb_en_d;
    logic [XLEN-1:0]    resp_vl_q, resp_vl_d;
    logic               cfg_changed_q, cfg_changed_d;

    logic [2:0]         vt_vsew;
    logic [2:0]         vt_vlmul;
    logic [10:0]        sew_bits;
    logic               is_frac;
    logic               frac_bad;
    logic               ill_nxt;
    logic [VL_BITS-1:0] vlmax;
    logic [CMP_W-1:0]   avl_w;
    logic [CMP_W-1:0]   vlmax_w;
    logic [VL_BITS-1:0] vl_calc;
`ifdef RVV_CFG_FRAC_LMUL_EN
    logic [2:0]         frac_sh;
    logic [13:0]        frac_ratio;
`endif

    // Decode the requested vtype: legality, VLMAX and the clamped vl.
    always_comb begin
        vt_vsew  = req_vtype[5:3];
        vt_vlmul = req_vtype[2:0];
        sew_bits = 11'd8 << vt_vsew;
        is_frac  = vt_vlmul[2] && (vt_vlmul != 3'b100);
        vlmax    = (VLEN_C >> (5'd3 + {2'b00, vt_vsew})) << vt_vlmul[1:0];
`ifdef RVV_CFG_FRAC_LMUL_EN
        // 1/2^frac_sh: vlmul 101 -> 3, 110 -> 2, 111 -> 1
        frac_sh    = 3'(4'd8 - {1'b0, vt_vlmul});
        frac_ratio = {3'b000, sew_bits} << frac_sh;
        frac_bad   = is_frac && (frac_ratio > {3'b000, ELEN_C});
        if (is_frac) begin
            vlmax = VLEN_C >> (5'd3 + {2'b00, vt_vsew} + {2'b00, frac_sh});
        end
`else
        frac_bad = is_frac;
`endif
        ill_nxt = (|req_vtype[XLEN-1:8]) || (vt_vlmul == 3'b100) ||
                  (sew_bits > ELEN_C) || frac_bad;

        // rs1=x0, rd=x0 keeps the current vl, still clamped to the new VLMAX
        if (req_cfg_type == 2'b11) begin
            avl_w = CMP_W'(req_avl[4:0]);
        end else if (!req_rs1_x0) begin
            avl_w = CMP_W'(req_avl);
        end else if (!req_rd_x0) begin
            avl_w = '1;
        end else begin
            avl_w = CMP_W'(vl_q);
        end
        vlmax_w = CMP_W'(vlmax);
        vl_calc = (avl_w < vlmax_w) ? VL_BITS'(avl_w) : vlmax;
    end

    // Handshake FSM and next architectural state.
    always_comb begin
        state_d       = state_q;
        vl_d          = vl_q;
        vsew_d        = vsew_q;
        vlmul_d       = vlmul_q;
        vta_d         = vta_q;
        vma_d         = vma_q;
        vill_d        = vill_q;
        resp_wb_en_d  = resp_wb_en_q;
        resp_vl_d     = resp_vl_q;
        cfg_changed_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d       = ST_RESP;
                    cfg_changed_d = 1'b1;
                    resp_wb_en_d  = !req_rd_x0;
                    if (ill_nxt) begin
                        vl_d      = '0;
                        vsew_d    = 3'b000;
                        vlmul_d   = 3'b000;
                        vta_d     = 1'b0;
                        vma_d     = 1'b0;
                        vill_d    = 1'b1;
                        resp_vl_d = '0;
                    end else begin
                        vl_d      = vl_calc;
                        vsew_d    = vt_vsew;
                        vlmul_d   = vt_vlmul;
                        vta_d     = req_vtype[6];
                        vma_d     = req_vtype[7];
                        vill_d    = 1'b0;
                        resp_vl_d = XLEN'(vl_calc);
                    end
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops any pending response and marks vtype illegal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vl_q          <= '0;
            vsew_q        <= 3'b000;
            vlmul_q       <= 3'b000;
            vta_q         <= 1'b0;
            vma_q         <= 1'b0;
            vill_q        <= 1'b1;
            resp_wb_en_q  <= 1'b0;
            resp_vl_q     <= '0;
            cfg_changed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vl_q          <= vl_d;
            vsew_q        <= vsew_d;
            vlmul_q       <= vlmul_d;
            vta_q         <= vta_d;
            vma_q         <= vma_d;
            vill_q        <= vill_d;
            resp_wb_en_q  <= resp_wb_en_d;
            resp_vl_q     <= resp_vl_d;
            cfg_changed_q <= cfg_changed_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = (state_q == ST_RESP);
    assign resp_wb_en  = resp_wb_en_q;
    assign resp_vl     = resp_vl_q;
    assign vl          = vl_q;
    assign vsew        = vsew_q;
    assign vlmul       = vlmul_q;
    assign vta         = vta_q;
    assign vma         = vma_q;
    assign vill        = vill_q;
    assign cfg_changed = cfg_changed_q;

endmodule

// File: tb/tb_vcfg_ctrl.sv
// Bench for vcfg_ctrl: directed RVV vset* cases with literal expectations,
// then randomized traffic checked every cycle against an arithmetic model.
module tb_vcfg_ctrl;
    localparam int XLEN    = 32;
    localparam int VLEN    = 16384;
    localparam int ELEN    = 64;
    localparam int VL_BITS = $clog2(VLEN) + 1;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_cfg_type;
    logic               req_rs1_x0;
    logic               req_rd_x0;
    logic [XLEN-1:0]    req_avl;
    logic [XLEN-1:0]    req_vtype;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_wb_en;
    logic [XLEN-1:0]    resp_vl;
    logic [VL_BITS-1:0] vl;
    logic [2:0]         vsew;
    logic [2:0]         vlmul;
    logic               vta;
    logic               vma;
    logic               vill;
    logic               cfg_changed;

    int checks   = 0;
    int failures = 0;
    int last_wait;
    bit cmp_en = 0;

    vcfg_ctrl #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN), .VL_BITS(VL_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cfg_type(req_cfg_type), .req_rs1_x0(req_rs1_x0), .req_rd_x0(req_rd_x0),
        .req_avl(req_avl), .req_vtype(req_vtype),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_wb_en(resp_wb_en), .resp_vl(resp_vl),
        .vl(vl), .vsew(vsew), .vlmul(vlmul), .vta(vta), .vma(vma), .vill(vill),
        .cfg_changed(cfg_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: what vl/vill a config instruction must produce.
    function automatic void ref_cfg(input logic [1:0] t, input logic rs1x0, input logic rdx0,
                                    input logic [31:0] avl, input logic [31:0] vt,
                                    input longint cur_vl, output bit ill, output longint vlo);
        longint sew, num, den, vlmax, a;
        int vs, vm;
        vs  = int'(vt[5:3]);
        vm  = int'(vt[2:0]);
        sew = longint'(8) << vs;
        ill = (vt[31:8] != 0) || (vm == 4) || (sew > ELEN);
        if (vm < 4) begin
            num = longint'(1) << vm;
            den = 1;
        end else begin
            num = 1;
            den = longint'(1) << (8 - vm);
`ifdef RVV_CFG_FRAC_LMUL_EN
            if (vm != 4 && sew * den > ELEN) ill = 1;
`else
            ill = 1;
`endif
        end
        vlmax = (longint'(VLEN) * num) / (sew * den);
        if (t == 2'b11)  a = longint'(avl[4:0]);
        else if (!rs1x0) a = longint'(avl);
        else if (!rdx0)  a = 64'h0000_0000_FFFF_FFFF;
        else             a = cur_vl;
        vlo = ill ? 0 : ((a < vlmax) ? a : vlmax);
    endfunction

    // Model state
    bit     m_busy = 0, m_cfg = 0, m_vill = 1, m_wb = 0, m_vta = 0, m_vma = 0;
    int     m_vsew = 0, m_vlmul = 0;
    longint m_vl = 0, m_resp_vl = 0;

    task automatic model_reset();
        m_busy = 0; m_cfg = 0; m_vill = 1; m_wb = 0; m_vta = 0; m_vma = 0;
        m_vsew = 0; m_vlmul = 0; m_vl = 0; m_resp_vl = 0;
    endtask

    always @(negedge rst_n) model_reset();

    // Model advance on each clock edge
    always @(posedge clk) begin : model
        bit     acc, ill;
        longint v;
        if (!rst_n) begin
            model_reset();
        end else begin
            acc = req_valid && !m_busy;
            if (m_busy && resp_ready) m_busy = 0;
            m_cfg = acc;
            if (acc) begin
                ref_cfg(req_cfg_type, req_rs1_x0, req_rd_x0, req_avl, req_vtype, m_vl, ill, v);
                m_busy    = 1;
                m_wb      = !req_rd_x0;
                m_vill    = ill;
                m_vl      = v;
                m_resp_vl = v;
                m_vsew    = ill ? 0 : int'(req_vtype[5:3]);
                m_vlmul   = ill ? 0 : int'(req_vtype[2:0]);
                m_vta     = ill ? 1'b0 : req_vtype[6];
                m_vma     = ill ? 1'b0 : req_vtype[7];
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_ready", req_ready, !m_busy);
            chk("resp_valid", resp_valid, m_busy);
            chk("cfg_changed", cfg_changed, m_cfg);
            chk("vl", vl, m_vl);
            chk("vill", vill, m_vill);
            chk("vsew", vsew, m_vsew);
            chk("vlmul", vlmul, m_vlmul);
            chk("vta", vta, m_vta);
            chk("vma", vma, m_vma);
            if (m_busy) begin
                chk("resp_vl", resp_vl, m_resp_vl);
                chk("resp_wb_en", resp_wb_en, m_wb);
            end
        end
    end

    // One full request: offer, check literal result, hold, complete.
    task automatic do_req(input string tag, input logic [1:0] t, input logic rs1x0, input logic rdx0,
                          input logic [31:0] avl, input logic [31:0] vt, input int hold,
                          input longint exp_vl, input bit exp_vill, input bit exp_wb);
        int n;
        @(posedge clk); #1;
        req_valid = 1; req_cfg_type = t; req_rs1_x0 = rs1x0; req_rd_x0 = rdx0;
        req_avl = avl; req_vtype = vt; resp_ready = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 10);
        if (!resp_valid) chk({tag, "_accept_timeout"}, 0, 1);
        req_valid = 0;
        chk({tag, "_resp_vl"}, resp_vl, exp_vl);
        chk({tag, "_vl"}, vl, exp_vl);
        chk({tag, "_vill"}, vill, exp_vill);
        chk({tag, "_wb_en"}, resp_wb_en, exp_wb);
        chk({tag, "_cfg_changed"}, cfg_changed, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, resp_valid, 1);
            chk({tag, "_hold_req_ready"}, req_ready, 0);
            chk({tag, "_hold_resp_vl"}, resp_vl, exp_vl);
        end
        resp_ready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (resp_valid && n < 20);
        if (resp_valid) chk({tag, "_done_timeout"}, 0, 1);
        last_wait  = n;
        resp_ready = 0;
    endtask

    function automatic logic [31:0] rand_vtype();
        logic [31:0] vt;
        int r;
        r = $urandom_range(0, 9);
        vt = '0;
        vt[7:6] = 2'($urandom_range(0, 3));
        vt[5:3] = (r == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        vt[2:0] = 3'($urandom_range(0, 7));
        if (r == 1) vt[31:8] = 24'($urandom());
        if (r == 2) vt[31] = 1'b1;
        return vt;
    endfunction

    function automatic logic [31:0] rand_avl();
        logic [31:0] p;
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'($urandom_range(1, 64));
            2: return 32'($urandom_range(100, 20000));
            3: return $urandom();
            default: begin
                p = 32'd128 << $urandom_range(0, 7);
                return p + 32'($urandom_range(0, 2)) - 32'd1;
            end
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; req_valid = 0; req_cfg_type = 0; req_rs1_x0 = 0; req_rd_x0 = 0;
        req_avl = 0; req_vtype = 0; resp_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_vill", vill, 1);
        chk("rst_vl", vl, 0);
        chk("rst_vsew", vsew, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_wb_en", resp_wb_en, 0);
        chk("rst_resp_vl", resp_vl, 0);
        chk("rst_cfg_changed", cfg_changed, 0);
        cmp_en = 1;
        @(posedge clk); #2; rst_n = 1;

        // SEW32 LMUL1: VLMAX 512; held 3 cycles then released
        do_req("t1", 2'b00, 0, 0, 32'd1000, 32'h010, 3, 512, 0, 1);
        chk("t4_idle_latency", last_wait, 1);
        chk("t4_req_ready", req_ready, 1);
        do_req("t2a", 2'b11, 1, 0, 32'd31, 32'h003, 0, 31, 0, 1);
        do_req("t2b", 2'b00, 1, 0, 32'd0, 32'h019, 1, 512, 0, 1);
        do_req("keep", 2'b00, 1, 1, 32'd7, 32'h018, 0, 256, 0, 0);
        do_req("keep2", 2'b00, 1, 1, 32'd7, 32'h01A, 0, 256, 0, 0);
        do_req("t3a", 2'b10, 0, 0, 32'd100, 32'h004, 0, 0, 1, 1);
        chk("t3a_vsew", vsew, 0);
        do_req("t3b", 2'b10, 0, 0, 32'd100, 32'h8000_0000, 0, 0, 1, 1);
        chk("t3b_vsew", vsew, 0);
        do_req("avl0", 2'b00, 0, 0, 32'd0, 32'h010, 0, 0, 0, 1);
        do_req("avl_eq", 2'b00, 0, 1, 32'd512, 32'h010, 0, 512, 0, 0);
        do_req("avl_over", 2'b00, 0, 0, 32'd513, 32'h010, 0, 512, 0, 1);
        do_req("avl_big", 2'b00, 0, 0, 32'hFFFF_FFFF, 32'h003, 0, 16384, 0, 1);
        do_req("uimm", 2'b11, 1, 0, 32'hFFFF_FFE5, 32'h010, 0, 5, 0, 1);
        do_req("rsvd", 2'b01, 0, 0, 32'd100, 32'h010, 0, 100, 0, 1);
        do_req("sew128", 2'b00, 0, 0, 32'd100, 32'h020, 0, 0, 1, 1);
        do_req("hibit", 2'b00, 0, 0, 32'd100, 32'h110, 0, 0, 1, 1);
        do_req("tama", 2'b00, 0, 0, 32'd1000, 32'h0D0, 0, 512, 0, 1);
        chk("tama_vta", vta, 1);
        chk("tama_vma", vma, 1);
`ifdef RVV_CFG_FRAC_LMUL_EN
        do_req("t5a", 2'b00, 0, 0, 32'd1000, 32'h017, 0, 256, 0, 1);
        do_req("frac8", 2'b00, 0, 0, 32'd1000, 32'h005, 0, 256, 0, 1);
`else
        do_req("t5a", 2'b00, 0, 0, 32'd1000, 32'h017, 0, 0, 1, 1);
        do_req("frac8", 2'b00, 0, 0, 32'd1000, 32'h005, 0, 0, 1, 1);
`endif
        do_req("t5b", 2'b00, 0, 0, 32'd1000, 32'h01F, 0, 0, 1, 1);

        // Reset while the response is pending
        @(posedge clk); #1;
        req_valid = 1; req_cfg_type = 2'b00; req_rs1_x0 = 0; req_rd_x0 = 0;
        req_avl = 32'd1000; req_vtype = 32'h010; resp_ready = 0;
        @(posedge clk); #1;
        req_valid = 0;
        #2;
        chk("t6_pre_valid", resp_valid, 1);
        rst_n = 0;
        #1;
        chk("t6_valid", resp_valid, 0);
        chk("t6_vill", vill, 1);
        chk("t6_vl", vl, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2; rst_n = 1;
        do_req("t6_after", 2'b00, 0, 0, 32'd300, 32'h010, 0, 300, 0, 1);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst_n        = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            req_valid    = 1'($urandom_range(0, 1));
            resp_ready   = 1'($urandom_range(0, 1));
            req_cfg_type = 2'($urandom_range(0, 3));
            req_rs1_x0   = ($urandom_range(0, 3) == 0);
            req_rd_x0    = ($urandom_range(0, 3) == 0);
            req_avl      = rand_avl();
            req_vtype    = rand_vtype();
        end
        @(posedge clk); #1;
        rst_n = 1; req_valid = 0; resp_ready = 1;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
